dense1_scale_sequencer: RTL and testbench

DENSE1_SCALE_SEQUENCER -- requirements
Module: dense1_scale_sequencer

---
 rtl/dense1_scale_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dense1_scale_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense1_scale_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dense1_scale_sequencer
// Brief    : Per-channel requantization sequencer for a dense layer pass.
//            Each accumulator is multiplied by a ROM scale, then rounded,
//            shifted and ReLU6-clamped to an 8-bit activation.
// Revision : 1.0  initial release
// ============================================================================
module dense1_scale_sequencer #(
    parameter int NUM_CH = 128,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 8,
    parameter int Q6     = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             acc_valid,
    output logic             acc_ready,
    input  logic [ACC_W-1:0] acc_data,
    output logic [7:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [6:0]       out_ch,
    output logic             out_last
);

    localparam int CW = $clog2(NUM_CH + 1);
    localparam int PW = ACC_W + 9;

    localparam logic [CW-1:0]        c_num_ch  = CW'(NUM_CH);
    localparam logic [6:0]           c_last_ch = 7'(NUM_CH - 1);
    localparam logic signed [PW-1:0] c_half    = PW'(1) << (SHIFT - 1);
    localparam logic signed [PW-1:0] c_q6      = PW'(Q6);
    localparam logic [7:0]           c_q6_8    = 8'(Q6);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_ch_cnt;
    logic             r_s1_valid;
    logic [ACC_W-1:0] r_s1_acc;
    logic [7:0]       r_s1_scale;
    logic [6:0]       r_s1_ch;

    logic w_adv;
    logic w_cnt_open;
    logic w_acc_fire;
    logic w_out_fire;

    logic signed [PW-1:0] w_acc_ext;
    logic signed [PW-1:0] w_scale_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_sum;
    logic signed [PW-1:0] w_r;
    logic [7:0]           w_q;

    // The whole two-stage pipeline moves only when the output slot can free up.
    assign w_adv      = !out_valid || out_ready;
    assign w_cnt_open = (r_ch_cnt < c_num_ch);
    assign acc_ready  = (r_state == S_RUN) && w_adv && w_cnt_open;
    assign w_acc_fire = acc_valid && acc_ready;
    assign w_out_fire = out_valid && out_ready;
    assign rom_addr   = w_cnt_open ? 8'(r_ch_cnt) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_out_fire && out_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_ch_cnt <= '0;
        end else if (w_acc_fire) begin
            r_ch_cnt <= r_ch_cnt + 1'b1;
        end
    end

    // Stage 1: accumulator and its scale are captured together with the tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_acc   <= '0;
            r_s1_scale <= '0;
            r_s1_ch    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_acc_fire;
            if (w_acc_fire) begin
                r_s1_acc   <= acc_data;
                r_s1_scale <= rom_data;
                r_s1_ch    <= 7'(r_ch_cnt);
            end
        end
    end

    assign w_acc_ext   = {{9{r_s1_acc[ACC_W-1]}}, r_s1_acc};
    assign w_scale_ext = {{(PW-8){1'b0}}, r_s1_scale};
    assign w_prod      = w_acc_ext * w_scale_ext;
    assign w_sum       = w_prod + c_half;
    assign w_r         = w_sum >>> SHIFT;

    always_comb begin
        w_q = w_r[7:0];
        if (w_r[PW-1] || (w_r == '0)) begin
            w_q = 8'd0;
        end else if (w_r >= c_q6) begin
            w_q = c_q6_8;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data <= w_q;
                out_ch   <= r_s1_ch;
                out_last <= (r_s1_ch == c_last_ch);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dense1_scale_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense1_scale_sequencer
// Brief    : Self-checking bench for dense1_scale_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_dense1_scale_sequencer;

    localparam int NUM_CH = 128;
    localparam int ACC_W  = 24;
    localparam int SHIFT  = 8;
    localparam int Q6     = 96;
    localparam int NV     = 12;
    localparam int LIMIT  = 2000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done;
    logic             acc_valid = 1'b0;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_data = '0;
    logic [7:0]       rom_addr;
    logic [7:0]       rom_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic [6:0]       out_ch;
    logic             out_last;

    logic [7:0] rom [256];
    int         accv [NUM_CH];
    logic [7:0] expv [NUM_CH];

    typedef struct {
        int         acc;
        logic [7:0] scale;
        logic [7:0] exp_q;
    } vec_t;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    dense1_scale_sequencer #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .SHIFT(SHIFT), .Q6(Q6)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last)
    );

    task automatic chk(input string name, input longint act, input longint exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Requantization straight from the arithmetic definition.
    function automatic logic [7:0] model(input int acc, input int scale);
        longint p, r;
        p = longint'(acc) * longint'(scale);
        r = (p + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (r <= 0) return 8'd0;
        if (r >= Q6) return 8'(Q6);
        return r[7:0];
    endfunction

    task automatic prep(input bit use_tbl);
        for (int k = 0; k < NUM_CH; k++) begin
            if (use_tbl && k < NV) begin
                accv[k] = tbl[k].acc;
                rom[k]  = tbl[k].scale;
                expv[k] = tbl[k].exp_q;
            end else begin
                accv[k] = int'($urandom_range(0, 250)) - 100;
                rom[k]  = 8'($urandom_range(0, 255));
                expv[k] = model(accv[k], int'(rom[k]));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_acc_ready"}, acc_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_ch"}, out_ch, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        chk("idle_before_start", busy, 0);
        start     = 1'b1;
        acc_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    // mode 0: back-to-back, mode 1: random valid/ready/start, mode 2: 5-cycle stall
    task automatic run_pass(input int mode, input bit rst_at_40);
        int   n_in = 0, n_out = 0, cyc = 0, post = 0;
        int   acc_cyc [NUM_CH];
        bit   fin = 0, aborted = 0, prev_hold = 0;
        logic [7:0] pd;
        logic [6:0] pc;
        logic       pl;
        do_start();
        while (!fin && !aborted && cyc < LIMIT) begin
            @(negedge clk);
            if (post == 1)                    start = 1'b1;
            else if (mode == 1 && post == 0)  start = 1'($urandom_range(0, 1));
            else                              start = 1'b0;
            acc_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            acc_data  = (n_in < NUM_CH) ? accv[n_in][ACC_W-1:0] : ACC_W'($urandom);
            case (mode)
                1:       out_ready = ($urandom_range(0, 2) != 0);
                2:       out_ready = !(cyc >= 20 && cyc < 25);
                default: out_ready = 1'b1;
            endcase
            #1;
            if (post == 1) begin
                chk("done_pulse", done, 1);
                chk("busy_in_done", busy, 1);
                chk("no_out_after_last", out_valid, 0);
            end else if (post == 2) begin
                chk("done_one_cycle", done, 0);
                chk("busy_low_after", busy, 0);
                chk("acc_ready_idle", acc_ready, 0);
            end else if (post == 3) begin
                chk("start_in_done_ignored", busy, 0);
                fin = 1;
            end else begin
                chk("busy_run", busy, 1);
                chk("done_run", done, 0);
                chk("rom_addr", rom_addr, (n_in < NUM_CH) ? n_in : 0);
                if (n_in == NUM_CH) chk("no_accept_after_all", acc_ready, 0);
                if (out_valid && !out_ready) chk("acc_ready_stall", acc_ready, 0);
                if (prev_hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, pd);
                    chk("hold_ch", out_ch, pc);
                    chk("hold_last", out_last, pl);
                end
                if (acc_valid && acc_ready) begin
                    acc_cyc[n_in] = cyc;
                    n_in++;
                end
                if (out_valid && out_ready) begin
                    if (n_out >= n_in) begin
                        chk("phantom_output", n_out, n_in - 1);
                    end else begin
                        chk("out_data", out_data, expv[n_out]);
                        chk("out_ch", out_ch, n_out);
                        chk("out_last", out_last, (n_out == NUM_CH - 1));
                        if (mode == 0) chk("latency", cyc - acc_cyc[n_out], 2);
                        n_out++;
                    end
                end
                prev_hold = out_valid && !out_ready;
                pd = out_data;
                pc = out_ch;
                pl = out_last;
                if (rst_at_40 && n_in == 40) aborted = 1;
            end
            if (post > 0)               post++;
            else if (n_out == NUM_CH)   post = 1;
            cyc++;
        end
        if (rst_at_40) begin
            chk("reached_ch40", aborted, 1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            start = 1'b0;
            #1;
            check_reset_outputs("midpass_rst");
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                acc_valid = 1'b1;
                out_ready = 1'b1;
                #1;
                chk("post_rst_no_valid", out_valid, 0);
                chk("post_rst_no_done", done, 0);
                chk("post_rst_idle", busy, 0);
            end
        end else begin
            chk("pass_complete", fin, 1);
        end
    endtask

    initial begin
        tbl[0]  = '{256,      8'h5F, 8'd95};
        tbl[1]  = '{1000,     8'h5F, 8'd96};
        tbl[2]  = '{-500,     8'h5F, 8'd0};
        tbl[3]  = '{3,        8'h55, 8'd1};
        tbl[4]  = '{0,        8'hFF, 8'd0};
        tbl[5]  = '{100,      8'h80, 8'd50};
        tbl[6]  = '{1,        8'h7F, 8'd0};
        tbl[7]  = '{-1,       8'hFF, 8'd0};
        tbl[8]  = '{24447,    8'h01, 8'd95};
        tbl[9]  = '{24448,    8'h01, 8'd96};
        tbl[10] = '{8388607,  8'hFF, 8'd96};
        tbl[11] = '{-8388608, 8'hFF, 8'd0};
        for (int k = 0; k < 256; k++) rom[k] = 8'h00;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        prep(1'b1);
        run_pass(0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            prep(1'b0);
            run_pass(1, 1'b0);
        end
        prep(1'b0);
        run_pass(2, 1'b0);
        prep(1'b0);
        run_pass(0, 1'b1);
        prep(1'b1);
        run_pass(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
